// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream (valid/ready) and memory write port of the program loader.
interface program_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/word_packer.sv
// Packs big-endian stream bytes into memory words; pulses word_valid for one
// cycle with the completed word held on word.
module word_packer
    import loader_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic [7:0]        byte_in,
    output logic              at_last,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);
    localparam int unsigned BPW   = bytes_per_word(DATA_W);
    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] packed_word;

    assign at_last     = (cnt == CNT_W'(BPW - 1));
    assign packed_word = (shreg << 8) | DATA_W'(byte_in);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (shift) begin
                if (at_last) begin
                    word       <= packed_word;
                    word_valid <= 1'b1;
                    shreg      <= '0;
                    cnt        <= '0;
                end else begin
                    shreg <= packed_word;
                    cnt   <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses SYNC/COUNT/payload/CHK frames, writes words to memory
// and holds the CPU in reset until a frame with a matching checksum lands.
module program_loader
    import loader_pkg::*;
#(
    parameter int               DATA_W    = 16,
    parameter int               ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]       SYNC_BYTE = DEFAULT_SYNC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    program_loader_if.slave   bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int WL_W = ADDR_W + 1;

    state_t            state, state_nxt;
    logic [8:0]        total;
    logic [8:0]        widx;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] addr_q;
    logic              take;
    logic              at_last;
    logic              word_valid;
    logic [DATA_W-1:0] word;

    // restart wins over a byte accepted in the same cycle
    assign take = bus.in_valid && bus.in_ready && !restart;

    assign bus.in_ready  = (state != DONE) && (state != ERR);
    assign bus.mem_we    = word_valid;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = word;
    assign cpu_hold      = (state != DONE);
    assign done          = (state == DONE);
    assign error         = (state == ERR);

    word_packer #(.DATA_W(DATA_W)) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (restart || (take && state == LEN)),
        .shift      (take && state == DATA),
        .byte_in    (bus.in_data),
        .at_last    (at_last),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = IDLE;
        end else if (take) begin
            unique case (state)
                IDLE:    if (bus.in_data == SYNC_BYTE) state_nxt = LEN;
                LEN:     state_nxt = DATA;
                DATA:    if (at_last && widx == total - 9'd1) state_nxt = CHECK;
                CHECK:   state_nxt = (bus.in_data == sum) ? DONE : ERR;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            total        <= '0;
            widx         <= '0;
            sum          <= '0;
            addr_q       <= '0;
            words_loaded <= '0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                widx         <= '0;
                sum          <= '0;
                words_loaded <= '0;
            end else begin
                if (take && state == LEN) begin
                    // COUNT of zero encodes 256 words
                    total        <= {bus.in_data == 8'd0, bus.in_data};
                    widx         <= '0;
                    sum          <= '0;
                    words_loaded <= '0;
                end
                if (take && state == DATA) begin
                    sum <= sum + bus.in_data;
                    if (at_last) begin
                        addr_q <= BASE_ADDR + ADDR_W'(widx);
                        widx   <= widx + 9'd1;
                    end
                end
                if (word_valid) words_loaded <= words_loaded + WL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: two instances (base 0x00 and 0x80)
// fed the same stream, compared against a frame-level reference model.
module tb_program_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       restart;
    logic       vld;
    logic [7:0] dat;
    logic       hold0, done0, error0, hold1, done1, error1;
    logic [8:0] wl0, wl1;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]  stream[$];
    logic [23:0] got0[$], got1[$], exp0[$], exp1[$];
    bit          exp_done, exp_err;
    int          exp_wl;
    logic        we_prev0 = 1'b0, we_prev1 = 1'b0;

    typedef struct {
        int cnt;
        int ng;
        bit bad;
        bit stall;
        bit fixed;
        bit exp_done;
        bit exp_err;
    } vec_t;
    vec_t vt[6];

    logic [7:0] fg[3];
    logic [7:0] fp[4];

    always #5 clock = ~clock;

    program_loader_if #(.DATA_W(16), .ADDR_W(8)) bus0 ();
    program_loader_if #(.DATA_W(16), .ADDR_W(8)) bus1 ();
    assign bus0.in_valid = vld;
    assign bus0.in_data  = dat;
    assign bus1.in_valid = vld;
    assign bus1.in_data  = dat;

    program_loader #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(8'h00), .SYNC_BYTE(8'hA5)) dut0 (
        .clock(clock), .reset(reset), .restart(restart), .bus(bus0),
        .cpu_hold(hold0), .done(done0), .error(error0), .words_loaded(wl0)
    );

    program_loader #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(8'h80), .SYNC_BYTE(8'hA5)) dut1 (
        .clock(clock), .reset(reset), .restart(restart), .bus(bus1),
        .cpu_hold(hold1), .done(done1), .error(error1), .words_loaded(wl1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Write monitors: strobe never lasts two cycles, words_loaded counts prior writes
    always @(negedge clock) begin
        if (bus0.mem_we) begin
            check("we_pulse0", 32'(we_prev0), 0);
            check("wl_at_strobe0", 32'(wl0), 32'(got0.size()));
            got0.push_back({bus0.mem_addr, bus0.mem_wdata});
        end
        if (bus1.mem_we) begin
            check("we_pulse1", 32'(we_prev1), 0);
            got1.push_back({bus1.mem_addr, bus1.mem_wdata});
        end
        we_prev0 = bus0.mem_we;
        we_prev1 = bus1.mem_we;
    end

    task automatic send(input logic [7:0] b, input bit stall);
        stream.push_back(b);
        if (stall) begin
            vld = 1'b0;
            @(negedge clock);
        end
        vld = 1'b1;
        dat = b;
        @(negedge clock);
        vld = 1'b0;
    endtask

    task automatic start_frame();
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        repeat (2) @(negedge clock);
        got0.delete();
        got1.delete();
        stream.delete();
    endtask

    function automatic logic [7:0] rand_garbage();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        return b;
    endfunction

    // Reference: locate the first sync byte and decode the frame that follows
    task automatic build_expect();
        int         p;
        int         n;
        int         s;
        logic [15:0] wd;
        exp0.delete();
        exp1.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_wl   = 0;
        p = 0;
        s = 0;
        while (p < stream.size() && stream[p] != 8'hA5) p++;
        if (p + 1 >= stream.size()) return;
        n = (stream[p+1] == 8'h00) ? 256 : int'(stream[p+1]);
        p += 2;
        for (int k = 0; k < n; k++) begin
            wd = {stream[p], stream[p+1]};
            s += int'(stream[p]) + int'(stream[p+1]);
            exp0.push_back({8'(k), wd});
            exp1.push_back({8'(128 + k), wd});
            p += 2;
        end
        exp_wl   = n;
        exp_done = (stream[p] == 8'(s % 256));
        exp_err  = !exp_done;
    endtask

    task automatic compare_frame();
        repeat (3) @(negedge clock);
        build_expect();
        check("nwr0", 32'(got0.size()), 32'(exp0.size()));
        check("nwr1", 32'(got1.size()), 32'(exp1.size()));
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) check("wr0", 32'(got0[i]), 32'(exp0[i]));
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) check("wr1", 32'(got1[i]), 32'(exp1[i]));
        check("done0", 32'(done0), 32'(exp_done));
        check("error0", 32'(error0), 32'(exp_err));
        check("hold0", 32'(hold0), 32'(!exp_done));
        check("wl0", 32'(wl0), 32'(exp_wl));
        check("ready0", 32'(bus0.in_ready), 0);
        check("done1", 32'(done1), 32'(exp_done));
        check("wl1", 32'(wl1), 32'(exp_wl));
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] s8;
        int         n;
        int         cnt;
        bit         st;

        fg = '{8'h00, 8'hFF, 8'h5A};
        fp = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        vt[0] = '{2, 3, 0, 1, 1, 1, 0};
        vt[1] = '{1, 0, 0, 0, 0, 1, 0};
        vt[2] = '{3, 2, 1, 0, 0, 0, 1};
        vt[3] = '{5, 1, 0, 1, 0, 1, 0};
        vt[4] = '{0, 0, 0, 0, 0, 1, 0};
        vt[5] = '{4, 2, 1, 1, 0, 0, 1};

        reset = 1'b0; restart = 1'b0; vld = 1'b0; dat = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(bus0.in_ready), 1);
        check("rst_we", 32'(bus0.mem_we), 0);
        check("rst_addr", 32'(bus0.mem_addr), 0);
        check("rst_wdata", 32'(bus0.mem_wdata), 0);
        check("rst_hold", 32'(hold0), 1);
        check("rst_done", 32'(done0), 0);
        check("rst_error", 32'(error0), 0);
        check("rst_wl", 32'(wl0), 0);
        reset = 1'b1;
        @(negedge clock);

        // Basic load with cycle-exact write strobes
        start_frame();
        send(8'hA5, 0); send(8'h02, 0); send(8'h12, 0); send(8'h34, 0);
        check("b_we0", 32'(bus0.mem_we), 1);
        check("b_addr0", 32'(bus0.mem_addr), 32'h00);
        check("b_data0", 32'(bus0.mem_wdata), 32'h1234);
        check("b_addr0_hi", 32'(bus1.mem_addr), 32'h80);
        send(8'hAB, 0);
        check("b_we_low", 32'(bus0.mem_we), 0);
        check("b_wl1", 32'(wl0), 1);
        send(8'hCD, 0);
        check("b_we1", 32'(bus0.mem_we), 1);
        check("b_addr1", 32'(bus0.mem_addr), 32'h01);
        check("b_data1", 32'(bus0.mem_wdata), 32'hABCD);
        check("b_hold_pre", 32'(hold0), 1);
        send(8'hBE, 0);
        check("b_done", 32'(done0), 1);
        check("b_hold", 32'(hold0), 0);
        check("b_wl2", 32'(wl0), 2);
        check("b_ready", 32'(bus0.in_ready), 0);

        // Bad checksum: writes still happen, error sticks, input blocked
        start_frame();
        check("r_done_clr", 32'(done0), 0);
        check("r_hold", 32'(hold0), 1);
        check("r_wl_clr", 32'(wl0), 0);
        send(8'hA5, 0); send(8'h02, 0); send(8'h12, 0); send(8'h34, 0);
        send(8'hAB, 0); send(8'hCD, 0); send(8'hBF, 0);
        check("e_error", 32'(error0), 1);
        check("e_done", 32'(done0), 0);
        check("e_hold", 32'(hold0), 1);
        repeat (4) @(negedge clock);
        check("e_nwr", 32'(got0.size()), 2);
        check("e_ready", 32'(bus0.in_ready), 0);
        check("e_sticky", 32'(error0), 1);
        start_frame();
        check("e_err_clr", 32'(error0), 0);
        check("e_ready_back", 32'(bus0.in_ready), 1);

        // Restart collides with the 3rd payload byte
        send(8'hA5, 0); send(8'h02, 0); send(8'h12, 0); send(8'h34, 0);
        vld = 1'b1; dat = 8'hAB; restart = 1'b1;
        @(negedge clock);
        vld = 1'b0; restart = 1'b0;
        check("c_wl", 32'(wl0), 0);
        check("c_ready", 32'(bus0.in_ready), 1);
        send(8'hCD, 0);
        repeat (3) @(negedge clock);
        check("c_nwr", 32'(got0.size()), 1);
        got0.delete(); got1.delete(); stream.delete();
        send(8'hA5, 0); send(8'h01, 0); send(8'h56, 0); send(8'h78, 0); send(8'hCE, 0);
        compare_frame();
        check("c_done", 32'(done0), 1);

        // Asynchronous reset between edges right after a write
        start_frame();
        send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0);
        send(8'h33, 0); send(8'h44, 0);
        check("a_pre_addr", 32'(bus0.mem_addr), 1);
        check("a_pre_wl", 32'(wl0), 1);
        #2 reset = 1'b0;
        #1;
        check("a_we", 32'(bus0.mem_we), 0);
        check("a_addr", 32'(bus0.mem_addr), 0);
        check("a_wdata", 32'(bus0.mem_wdata), 0);
        check("a_wl", 32'(wl0), 0);
        check("a_hold", 32'(hold0), 1);
        check("a_ready", 32'(bus0.in_ready), 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            start_frame();
            s8 = 8'h00;
            st = vt[v].stall;
            for (int g = 0; g < vt[v].ng; g++) send(vt[v].fixed ? fg[g] : rand_garbage(), st);
            send(8'hA5, st);
            send(8'(vt[v].cnt), st);
            n = (vt[v].cnt == 0) ? 256 : vt[v].cnt;
            for (int k = 0; k < 2 * n; k++) begin
                b = vt[v].fixed ? fp[k] : 8'($urandom);
                s8 = s8 + b;
                send(b, st);
            end
            send(s8 + 8'(vt[v].bad), st);
            compare_frame();
            check("tbl_done", 32'(done0), 32'(vt[v].exp_done));
            check("tbl_error", 32'(error0), 32'(vt[v].exp_err));
            if (vt[v].cnt == 0) begin
                check("wrap128", got1.size() > 128 ? 32'(got1[128][23:16]) : 32'hFFFF, 0);
                check("wl256", 32'(wl1), 256);
            end
        end

        // Randomised frames with random garbage, stalls and checksum errors
        for (int r = 0; r < 10; r++) begin
            start_frame();
            s8 = 8'h00;
            cnt = int'($urandom_range(1, 8));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) send(rand_garbage(), 1'($urandom));
            send(8'hA5, 1'($urandom));
            send(8'(cnt), 1'($urandom));
            for (int k = 0; k < 2 * cnt; k++) begin
                b = 8'($urandom);
                s8 = s8 + b;
                send(b, 1'($urandom));
            end
            send(($urandom_range(0, 2) == 0) ? s8 + 8'($urandom_range(1, 255)) : s8, 1'($urandom));
            compare_frame();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader for the Von Neumann processor. It accepts a framed byte stream over a valid/ready interface and assembles it into memory-width words. It writes those words into the unified instruction/data memory through a dedicated write port. It holds the CPU in reset until a complete frame with a matching checksum has been loaded, so the CPU begins fetching from a freshly written image without a testbench preloading memory.

## Interface
- `DATA_W`, 16: memory word width in bits. Must be a multiple of 8 (BPW = DATA_W/8 bytes per word).
- `ADDR_W`, 8: memory address width.
- `BASE_ADDR`, 0: address of the first loaded word.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clock`  in  1  sole clock. All logic samples on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `restart`  in  1  one-cycle request to abandon the current state and await a new frame.
- `in_valid`  in  1  byte present on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `cpu_hold`  out  1  active-high reset to the CPU.
- `done`  out  1  frame loaded and checksum matched (sticky).
- `error`  out  1  checksum mismatch (sticky).
- `words_loaded`  out  ADDR_W+1  count of words written in the current frame.

## Operation
- Frame format: `SYNC_BYTE`, then COUNT (1 byte; 0 means 2^8 = 256 words), then COUNT×BPW payload bytes (big-endian within each word), then CHK.
- CHK is the 8-bit sum, modulo 256, of all payload bytes. SYNC and COUNT are excluded.
- A byte is accepted on a rising edge with `in_valid && in_ready`.
- States:
  - IDLE: accepts and discards every byte except `SYNC_BYTE`, which moves to LEN.
  - LEN: stores COUNT, clears the accumulator, word index and `words_loaded`, then moves to DATA.
  - DATA: shifts bytes into the word register. After BPW bytes it issues a write; after the last word it moves to CHECK.
  - CHECK: the accepted byte is compared with the accumulator. A match moves to DONE; a mismatch moves to ERR.
  - DONE / ERR: absorbing states. Only `restart` or `reset` leaves them.
- `in_ready` = 1 in IDLE, LEN, DATA and CHECK; 0 in DONE and ERR.
- Write n (0-based) goes to address (BASE_ADDR + n) mod 2^ADDR_W. The address wraps silently.
- `cpu_hold` = 1 in every state except DONE.
- Memory is written before the checksum is verified. After ERR the memory contents are don't-care, and the CPU stays held.
- `restart` takes priority over a byte accepted in the same cycle: that byte is dropped. Next state is IDLE; `done`, `error` and `words_loaded` clear and `cpu_hold` = 1. Any partial word is discarded.
- Asserting `reset` mid-frame behaves like `restart`, but acts immediately (asynchronously).

## Timing
- Reset values: state IDLE, `in_ready` 1 (decoded from state), `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 1, `done` 0, `error` 0, `words_loaded` 0.
- Write latency: `mem_we` is high for exactly one cycle, in the cycle after the edge that accepted a word's last byte.
  - `mem_addr` and `mem_wdata` are registered and valid in that same cycle.
  - `words_loaded` increments on the edge ending the strobe.
- `done` rises, and `cpu_hold` falls, in the cycle after the edge that accepted a matching CHK. `error` rises in the same cycle position for a mismatch.
- Throughput is one byte per cycle. Gaps in `in_valid` stall the state without side effects.

## Structure
- Package `loader_pkg`: state enum (IDLE, LEN, DATA, CHECK, DONE, ERR), default `SYNC_BYTE`, and the BPW derivation.
- One sub-module, `word_packer`: byte shift register plus byte counter. It emits a full word with a one-cycle `word_valid`, and clears on frame start, `restart` or `reset`.
- The top level holds the FSM, checksum accumulator, address counter and status flags.

## Test plan
- Basic load (DATA_W=16): stream A5 02 12 34 AB CD BE.
  - mem[0]=0x1234 and mem[1]=0xABCD, each with a single-cycle `mem_we`.
  - `done`=1, `cpu_hold`=0, `words_loaded`=2.
- Bad checksum: same frame ending in BF.
  - Both writes still occur, then `error`=1 with `cpu_hold` staying 1.
  - `in_ready`=0 until `restart`.
- Leading garbage and stalls: 00 FF 5A, then the basic frame with `in_valid` low every other cycle.
  - The garbage bytes cause no writes, and the result is identical to the basic load.
- Wrap and 256 words: BASE_ADDR=0x80, COUNT=0x00, 512 payload bytes.
  - Word 128 is written to address 0x00.
  - `words_loaded`=256, `done`=1.
- Restart collision: `restart` asserted in the same cycle as the 3rd payload byte.
  - That byte is dropped, no write occurs, and the state returns to IDLE.
  - A following complete frame loads correctly.
- Async reset mid-DATA: `reset` driven low between edges.
  - Outputs take their reset values immediately, and `cpu_hold`=1.
